timer_multi: RTL and testbench
==============================

// Module: timer_multi
// PURPOSE
//  Multi-channel prescaled timer, successor to the single-channel timer.
//  One shared prescaler feeds CHANNELS independent period counters.
//  Each channel supports periodic or one-shot mode, synchronous restart, a compare-based PWM output and a readable count.
//  Fully synchronous single clock domain: the prescaler produces a clock-enable, never a derived clock.
//  Drives periodic interrupts and PWM for downstream peripheral blocks.
// PARAMETERS
//  CHANNELS     4   number of independent timer channels
//  WIDTH        32  period/compare/count width per channel
//  PRESC_WIDTH  32  prescaler width
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst_n      in   1                  reset, asynchronous, active-low
//  prescaler  in   PRESC_WIDTH        shared divide value; clock-enable every prescaler+1 clk
//  period     in   CHANNELS*WIDTH     per-channel terminal count, ch i = [i*WIDTH +: WIDTH]
//  compare    in   CHANNELS*WIDTH     per-channel PWM threshold, same packing
//  enable     in   CHANNELS           level; channel runs while high
//  one_shot   in   CHANNELS           1 = stop after first wrap, 0 = periodic
//  restart    in   CHANNELS           1-clk pulse; clears channel count and prescaler phase
//  tick       out  CHANNELS           1-clk pulse on each channel wrap
//  pwm        out  CHANNELS           high while running and count < compare
//  busy       out  CHANNELS           channel in RUN state
//  count      out  CHANNELS*WIDTH     current channel count, same packing
// BEHAVIOUR
//  Reset (rst_n low, async)
//   - all channels IDLE; presc_cnt=0.
//   - tick, pwm, busy and count are all 0.
//  Prescaler
//   - presc_cnt advances only while any channel is RUN; otherwise held at 0.
//   - ce = (presc_cnt == prescaler) && any RUN. When ce is high, presc_cnt <= 0; otherwise presc_cnt+1.
//   - prescaler=0 is legal: ce is high every clk.
//   - prescaler changed below presc_cnt: compare with ==, so presc_cnt wraps through 2^PRESC_WIDTH.
//  Restart and phase
//   - any restart bit high clears presc_cnt to 0 for all channels. Software restarts channels together for phase alignment.
//   - channels enabled at different times share prescaler phase, with a first-period error of up to prescaler clk.
//  Per-channel states: IDLE, RUN, DONE. Priority per edge: !enable > restart > ce.
//   - enable low: state IDLE, count cleared to 0, tick=0.
//   - IDLE & enable: state RUN, count=0.
//   - RUN & restart: count=0, stay RUN; no tick.
//   - RUN & ce & (count >= period): count <= 0; tick <= 1 for exactly 1 clk; if one_shot, state DONE.
//     Using >= ensures a period lowered mid-run wraps on the next ce.
//   - RUN & ce & (count < period): count <= count+1.
//   - DONE: count held at 0, pwm=0, busy=0. Leaves on restart (-> RUN) or enable low (-> IDLE).
//  tick is registered; it is 0 in every cycle without a wrap.
//  Latency and frequency
//   - enable sampled at edge 0: first tick is high after edge (prescaler+1)*(period+1).
//   - f_tick = f_clk / ((prescaler+1)*(period+1)).
//  pwm is combinational from registered state: busy && (count < compare).
//   - compare=0: pwm is constantly 0.
//   - compare > period: pwm is constantly 1 while running.
//  period=0: tick on every ce.
//  one_shot toggled mid-run takes effect at the next wrap.
//  Reset mid-operation returns to the reset values immediately; no tick is emitted.
// TESTING
//  1. prescaler=1, period[0]=3, enable=0001 periodic
//     -> tick[0] high 1 clk every 8 clk; first tick after edge 8; count[0] steps 0..3.
//  2. prescaler=0, period[1]=4, compare[1]=2
//     -> pwm[1] pattern 1,1,0,0,0 repeating; duty 2/5; tick[1] every 5 clk.
//  3. one_shot[2]=1, prescaler=0, period[2]=2
//     -> single tick at edge 3, busy[2] falls, no further ticks; restart pulse -> next tick 3 clk later.
//  4. Channel 0 running with count=10, period[0] changed to 5
//     -> wrap and tick on next ce; then period 6 ce.
//  5. All four channels enabled with different periods (1,2,3,7), prescaler=2
//     -> independent tick rates 1/6, 1/9, 1/12, 1/24 clk.
//     Disable ch3 mid-run -> count[3]=0, busy[3]=0 next clk; others unaffected.
//  6. rst_n asserted mid-period, asynchronous to clk
//     -> all outputs 0 before next clk edge; after release, channels stay IDLE until enable is seen.

Source files
------------

// File: rtl/timer_multi_if.sv
// Bus bundle for timer_multi: shared prescaler, packed per-channel config and status.
// The slave modport is the timer; the master modport is the controlling block.
interface timer_multi_if #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PRESC_WIDTH = 32
);
    logic [PRESC_WIDTH-1:0]    prescaler;
    logic [CHANNELS*WIDTH-1:0] period;
    logic [CHANNELS*WIDTH-1:0] compare;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       one_shot;
    logic [CHANNELS-1:0]       restart;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       pwm;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS*WIDTH-1:0] count;

    modport master (
        output prescaler, period, compare, enable, one_shot, restart,
        input  tick, pwm, busy, count
    );

    modport slave (
        input  prescaler, period, compare, enable, one_shot, restart,
        output tick, pwm, busy, count
    );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel timer: one shared prescaler clock-enable drives CHANNELS independent
// period counters, each with periodic/one-shot mode, restart, tick pulse and PWM compare.
module timer_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PRESC_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    timer_multi_if.slave  bus
);
    logic [PRESC_WIDTH-1:0] r_presc_cnt;
    logic [CHANNELS-1:0]    w_run;
    logic                   w_any_run;
    logic                   w_ce;

    assign w_any_run = |w_run;
    assign w_ce      = w_any_run && (r_presc_cnt == bus.prescaler);

    // Equality compare: a prescaler lowered below the current phase wraps through 2^PRESC_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
        end else if (!w_any_run || (|bus.restart) || w_ce) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + 1'b1;
        end
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           r_state;
        logic [WIDTH-1:0] r_count;
        logic             r_tick;
        logic [WIDTH-1:0] w_period;
        logic [WIDTH-1:0] w_compare;

        assign w_period  = bus.period[g*WIDTH +: WIDTH];
        assign w_compare = bus.compare[g*WIDTH +: WIDTH];

        // Priority per edge: enable low, then restart, then clock-enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_tick  <= 1'b0;
            end else if (!bus.enable[g]) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_RUN;
                        r_count <= '0;
                    end
                    S_RUN: begin
                        if (bus.restart[g]) begin
                            r_count <= '0;
                        end else if (w_ce) begin
                            // >= lets a period lowered below the count wrap on the next ce.
                            if (r_count >= w_period) begin
                                r_count <= '0;
                                r_tick  <= 1'b1;
                                if (bus.one_shot[g]) begin
                                    r_state <= S_DONE;
                                end
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_count <= '0;
                        if (bus.restart[g]) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end
                endcase
            end
        end

        assign w_run[g]                     = (r_state == S_RUN);
        assign bus.busy[g]                  = w_run[g];
        assign bus.tick[g]                  = r_tick;
        assign bus.pwm[g]                   = w_run[g] && (r_count < w_compare);
        assign bus.count[g*WIDTH +: WIDTH]  = r_count;
    end
endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: linear stimulus, immediate-assertion checks against
// hand-computed expectations, sampled 1 time unit after each rising edge.
module tb_timer_multi;
    localparam int unsigned CH = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned PW = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    timer_multi_if #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW)) bus ();

    timer_multi #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] cnt(input int ch);
        return bus.count[ch*W +: W];
    endfunction

    task automatic set_period(input int ch, input logic [W-1:0] v);
        bus.period[ch*W +: W] = v;
    endtask

    task automatic set_compare(input int ch, input logic [W-1:0] v);
        bus.compare[ch*W +: W] = v;
    endtask

    initial begin
        logic [CH-1:0] exp_tick;
        int            t_per [CH];

        rst_n         = 1'b0;
        bus.prescaler = '0;
        bus.period    = '0;
        bus.compare   = '0;
        bus.enable    = '0;
        bus.one_shot  = '0;
        bus.restart   = '0;
        #2;
        chk("rst_tick",  bus.tick,  '0);
        chk("rst_pwm",   bus.pwm,   '0);
        chk("rst_busy",  bus.busy,  '0);
        chk("rst_count", bus.count, '0);

        // Test 1: prescaler=1, period[0]=3, periodic
        @(negedge clk);
        rst_n         = 1'b1;
        bus.prescaler = 1;
        set_period(0, 3);
        bus.enable    = 4'b0001;
        clk_n(1);
        chk("t1_busy_e0", bus.busy, 4'b0001);
        chk("t1_cnt_e0",  cnt(0), 0);
        for (int e = 1; e <= 16; e++) begin
            clk_n(1);
            chk($sformatf("t1_cnt_e%0d", e),  cnt(0), (e / 2) % 4);
            chk($sformatf("t1_tick_e%0d", e), bus.tick[0], (e % 8) == 0);
            chk($sformatf("t1_pwm_e%0d", e),  bus.pwm[0], 1'b0);
        end
        bus.enable = '0;
        clk_n(2);

        // Test 2: prescaler=0, period[1]=4, compare[1]=2 -> pwm 1,1,0,0,0
        bus.prescaler = 0;
        set_period(1, 4);
        set_compare(1, 2);
        bus.enable = 4'b0010;
        clk_n(1);
        chk("t2_pwm_e0", bus.pwm[1], 1'b1);
        for (int e = 1; e <= 10; e++) begin
            clk_n(1);
            chk($sformatf("t2_cnt_e%0d", e),  cnt(1), e % 5);
            chk($sformatf("t2_pwm_e%0d", e),  bus.pwm[1], (e % 5) < 2);
            chk($sformatf("t2_tick_e%0d", e), bus.tick[1], (e % 5) == 0);
        end
        set_compare(1, 9);
        for (int e = 0; e < 5; e++) begin
            clk_n(1);
            chk($sformatf("t2_pwm_hi_%0d", e), bus.pwm[1], 1'b1);
        end
        bus.enable = '0;
        clk_n(2);

        // Test 3: one-shot channel 2, period 2, then restart
        set_period(2, 2);
        bus.one_shot = 4'b0100;
        bus.enable   = 4'b0100;
        clk_n(1);
        chk("t3_busy_e0", bus.busy, 4'b0100);
        for (int e = 1; e <= 3; e++) begin
            clk_n(1);
            chk($sformatf("t3_cnt_e%0d", e),  cnt(2), e % 3);
            chk($sformatf("t3_tick_e%0d", e), bus.tick[2], e == 3);
        end
        chk("t3_busy_done", bus.busy[2], 1'b0);
        for (int e = 4; e <= 6; e++) begin
            clk_n(1);
            chk($sformatf("t3_done_tick_e%0d", e), bus.tick, '0);
            chk($sformatf("t3_done_busy_e%0d", e), bus.busy, '0);
            chk($sformatf("t3_done_cnt_e%0d", e),  cnt(2), 0);
        end
        bus.restart = 4'b0100;
        clk_n(1);
        bus.restart = '0;
        chk("t3_rs_busy", bus.busy[2], 1'b1);
        chk("t3_rs_cnt",  cnt(2), 0);
        for (int e = 1; e <= 3; e++) begin
            clk_n(1);
            chk($sformatf("t3_rs_tick_e%0d", e), bus.tick[2], e == 3);
        end
        chk("t3_rs_busy_done", bus.busy[2], 1'b0);
        bus.enable   = '0;
        bus.one_shot = '0;
        clk_n(2);

        // Test 4: period lowered below current count, then restart mid-run
        set_period(0, 20);
        bus.enable = 4'b0001;
        clk_n(1);
        clk_n(10);
        chk("t4_cnt10", cnt(0), 10);
        set_period(0, 5);
        clk_n(1);
        chk("t4_wrap_tick", bus.tick[0], 1'b1);
        chk("t4_wrap_cnt",  cnt(0), 0);
        for (int e = 1; e <= 5; e++) begin
            clk_n(1);
            chk($sformatf("t4_cnt_%0d", e),  cnt(0), e);
            chk($sformatf("t4_tick_%0d", e), bus.tick[0], 1'b0);
        end
        clk_n(1);
        chk("t4_tick6", bus.tick[0], 1'b1);
        clk_n(3);
        chk("t4_cnt3", cnt(0), 3);
        bus.restart = 4'b0001;
        clk_n(1);
        bus.restart = '0;
        chk("t4_rs_cnt",  cnt(0), 0);
        chk("t4_rs_tick", bus.tick[0], 1'b0);
        chk("t4_rs_busy", bus.busy[0], 1'b1);
        clk_n(1);
        chk("t4_rs_cnt1", cnt(0), 1);
        bus.enable = '0;
        clk_n(2);

        // Test 5: four channels, prescaler=2, periods 1,2,3,7
        bus.prescaler = 2;
        set_period(0, 1);
        set_period(1, 2);
        set_period(2, 3);
        set_period(3, 7);
        bus.compare = '0;
        t_per[0] = 6;
        t_per[1] = 9;
        t_per[2] = 12;
        t_per[3] = 24;
        bus.enable = 4'b1111;
        clk_n(1);
        chk("t5_busy_e0", bus.busy, 4'b1111);
        for (int e = 1; e <= 28; e++) begin
            clk_n(1);
            for (int c = 0; c < 4; c++) exp_tick[c] = (e % t_per[c]) == 0;
            chk($sformatf("t5_tick_e%0d", e), bus.tick, exp_tick);
            chk($sformatf("t5_cnt3_e%0d", e), cnt(3), (e / 3) % 8);
        end
        bus.enable = 4'b0111;
        clk_n(1);
        chk("t5_dis_cnt3", cnt(3), 0);
        chk("t5_dis_busy", bus.busy, 4'b0111);
        chk("t5_dis_cnt0", cnt(0), 1);
        chk("t5_dis_cnt1", cnt(1), 0);
        chk("t5_dis_cnt2", cnt(2), 1);
        clk_n(1);
        chk("t5_tick_e30", bus.tick, 4'b0001);

        // Test 6: asynchronous reset mid-period
        clk_n(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tick",  bus.tick,  '0);
        chk("t6_pwm",   bus.pwm,   '0);
        chk("t6_busy",  bus.busy,  '0);
        chk("t6_count", bus.count, '0);
        @(negedge clk);
        bus.enable = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clk_n(2);
        chk("t6_idle_busy", bus.busy, '0);
        bus.prescaler = 0;
        bus.enable    = 4'b0001;
        clk_n(1);
        chk("t6_run_busy", bus.busy, 4'b0001);
        chk("t6_run_cnt",  cnt(0), 0);
        clk_n(2);
        chk("t6_run_tick", bus.tick[0], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
